uart_tx_scheduler: RTL

Arbitrates the single UART transmitter between the two byte sources on the sender board: decoded keyboard characters and the switch value latched on the button. Each source pushes one-cycle byte strobes into its own small FIFO. The scheduler drains both FIFOs round-robin and issues one `en_send` pulse per byte. It then waits for the UART's `tx_busy` handshake to complete before starting the next byte. It sits between the keyboard/button front end and the `uart` instance, replacing direct `send_data`/`en_send` drive.

---
 rtl/uart_sched_pkg.sv | 23 ++
 rtl/byte_fifo.sv | 48 ++++
 rtl/uart_tx_scheduler.sv | 127 ++++++++++++
 3 files changed

// File: rtl/uart_sched_pkg.sv
// Shared types and helpers for the UART transmit scheduler: FSM states,
// grant encoding and the handshake timer width.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } sched_state_t;

  typedef enum logic {
    GRANT_KEY = 1'b0,
    GRANT_SW  = 1'b1
  } grant_t;

  localparam int BYTE_W = 8;

  function automatic int timer_width(input int busy_wait);
    return $clog2(busy_wait + 1);
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small byte FIFO with extra-MSB pointers; a push into a full FIFO is
// accepted only when the head is popped in the same cycle.
module byte_fifo
  import uart_sched_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = BYTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_en;
  logic              rd_en;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between the keyboard
// and switch byte sources, one en_send per byte with a tx_busy handshake.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int BUSY_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] key_data,
  input  logic              key_valid,
  input  logic [BYTE_W-1:0] sw_data,
  input  logic              sw_valid,
  input  logic              tx_busy,
  input  logic              clear_drop,
  output logic [BYTE_W-1:0] send_data,
  output logic              en_send,
  output logic              key_drop,
  output logic              sw_drop,
  output logic              busy_timeout
);

  localparam int TIMER_W = timer_width(BUSY_WAIT);

  sched_state_t      state, state_nxt;
  grant_t            last_grant, grant;
  logic [TIMER_W-1:0] timer, timer_nxt;
  logic              do_grant, timeout;
  logic              key_full, key_empty, sw_full, sw_empty;
  logic              key_pop, sw_pop;
  logic [BYTE_W-1:0] key_head, sw_head;

  byte_fifo #(.DEPTH(DEPTH), .DATA_W(BYTE_W)) u_key_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (key_valid),
    .pop   (key_pop),
    .din   (key_data),
    .full  (key_full),
    .empty (key_empty),
    .head  (key_head)
  );

  byte_fifo #(.DEPTH(DEPTH), .DATA_W(BYTE_W)) u_sw_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (sw_valid),
    .pop   (sw_pop),
    .din   (sw_data),
    .full  (sw_full),
    .empty (sw_empty),
    .head  (sw_head)
  );

  // A lone non-empty source wins; on a tie the source not served last wins.
  always_comb begin
    grant = GRANT_KEY;
    if (key_empty)
      grant = GRANT_SW;
    else if (!sw_empty && last_grant == GRANT_KEY)
      grant = GRANT_SW;
  end

  assign key_pop = do_grant && (grant == GRANT_KEY);
  assign sw_pop  = do_grant && (grant == GRANT_SW);

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    do_grant  = 1'b0;
    timeout   = 1'b0;
    en_send   = 1'b0;
    case (state)
      IDLE: begin
        if (!tx_busy && (!key_empty || !sw_empty)) begin
          do_grant  = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        en_send   = 1'b1;
        timer_nxt = TIMER_W'(BUSY_WAIT);
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else begin
          timer_nxt = timer - 1'b1;
          if (timer <= TIMER_W'(1)) begin
            timeout   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // New drop/timeout events take priority over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      timer        <= '0;
      last_grant   <= GRANT_SW;
      send_data    <= '0;
      key_drop     <= 1'b0;
      sw_drop      <= 1'b0;
      busy_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      if (do_grant) begin
        last_grant <= grant;
        send_data  <= (grant == GRANT_KEY) ? key_head : sw_head;
      end
      key_drop     <= (key_valid && key_full && !key_pop) || (key_drop && !clear_drop);
      sw_drop      <= (sw_valid && sw_full && !sw_pop) || (sw_drop && !clear_drop);
      busy_timeout <= timeout || (busy_timeout && !clear_drop);
    end
  end

endmodule
